multi_cycle_control: RTL and testbench

- Main control FSM of the multi-cycle MIPS datapath.
- Sits directly downstream of the instruction memory unit. Consumes the opcode field (instruction[31:26]) once the instruction register has latched it.
- Sequences each instruction through fetch, decode, execute, memory and write-back steps.
- Drives every datapath enable and mux select, and stalls on a data-memory ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/control_word_decode.sv | 83 ++++++++
 rtl/multi_cycle_control.sv | 128 ++++++++++++
 tb/tb_multi_cycle_control.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: opcodes,
// state codes, datapath select codes and the packed control word.
// Optional feature macro: MULTI_CYCLE_ADDI_EN (adds the addi states).
package mips_ctrl_pkg;

  localparam int STATE_BITS = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_BITS-1:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } stateT;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluOpT;

  typedef enum logic [1:0] {
    SRCB_REG      = 2'b00,
    SRCB_FOUR     = 2'b01,
    SRCB_IMM      = 2'b10,
    SRCB_IMM_SHL2 = 2'b11
  } aluSrcBT;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pcSourceT;

  typedef struct packed {
    logic     pcWrite;
    logic     pcWriteCond;
    pcSourceT pcSource;
    logic     iorD;
    logic     memRead;
    logic     memWrite;
    logic     irWrite;
    logic     memToReg;
    logic     regDst;
    logic     regWrite;
    logic     aluSrcA;
    aluSrcBT  aluSrcB;
    aluOpT    aluOp;
  } ctrlWordT;

  localparam ctrlWordT CTRL_IDLE = '0;

endpackage

// File: rtl/control_word_decode.sv
// Moore output decode: maps the FSM state to the full datapath control word.
// Optional feature macro: MULTI_CYCLE_ADDI_EN (decodes ADDI_EXEC/ADDI_WB).
module control_word_decode
  import mips_ctrl_pkg::*;
(
  input  stateT    state,
  output ctrlWordT ctrl
);

  // Per-state control word; anything not named for a state stays 0.
  always_comb begin
    // NOTE: assigning the whole word first guarantees every field is driven on
    // every path, so no latch is inferred for fields a state does not touch.
    ctrl = CTRL_IDLE;
    case (state)
      FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.irWrite  = 1'b1;
        ctrl.pcWrite  = 1'b1;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.aluOp    = ALU_ADD;
        ctrl.pcSource = PC_ALU;
      end
      DECODE: begin
        ctrl.aluSrcB = SRCB_IMM_SHL2;
        ctrl.aluOp   = ALU_ADD;
      end
      MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      MEM_READ: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      MEM_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
        ctrl.regDst   = 1'b0;
      end
      MEM_WRITE: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
      end
      EXECUTE: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REG;
        ctrl.aluOp   = ALU_FUNCT;
      end
      R_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
        ctrl.memToReg = 1'b0;
      end
      BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_REG;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PC_ALUOUT;
      end
      JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PC_JUMP;
      end
`ifdef MULTI_CYCLE_ADDI_EN
      ADDI_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      ADDI_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b0;
        ctrl.memToReg = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: state register, captured
// opcode for the lw/sw split, reset gating of outputs and retired counter.
// Optional feature macro: MULTI_CYCLE_ADDI_EN (addi via ADDI_EXEC/ADDI_WB).
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic [1:0]          pcSource,
  output logic                iorD,
  output logic                memRead,
  output logic                memWrite,
  output logic                irWrite,
  output logic                memToReg,
  output logic                regDst,
  output logic                regWrite,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          aluOp,
  output logic                illegalOp,
  output logic [STATE_W-1:0]  state,
  output logic [RETIRE_W-1:0] retiredCount
);

  stateT         stateReg;
  stateT         nextState;
  logic [5:0]    heldOp;
  logic          illegalDecode;
  logic          retire;
  logic [RETIRE_W-1:0] retireCnt;
  ctrlWordT      ctrlRaw;
  ctrlWordT      ctrl;

  // State register and retired-instruction counter, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // so the order of statements here cannot change behaviour.
    if (reset) begin
      stateReg  <= FETCH;
      retireCnt <= '0;
    end else begin
      stateReg <= nextState;
      if (retire) retireCnt <= retireCnt + RETIRE_W'(1);
    end
  end

  // Opcode captured in DECODE so MEM_ADDR can choose read or write.
  always_ff @(posedge clk) begin
    // NOTE: no reset on purpose; heldOp is only read in MEM_ADDR, which is
    // always preceded by a DECODE that loads it.
    if (stateReg == DECODE) heldOp <= opcode;
  end

  // Next-state selection, illegal-opcode detection and retire strobe.
  always_comb begin
    nextState     = FETCH;
    illegalDecode = 1'b0;
    retire        = 1'b0;
    case (stateReg)
      FETCH:  nextState = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nextState = MEM_ADDR;
          OP_RTYPE:     nextState = EXECUTE;
          OP_BEQ:       nextState = BRANCH;
          OP_J:         nextState = JUMP;
`ifdef MULTI_CYCLE_ADDI_EN
          OP_ADDI:      nextState = ADDI_EXEC;
`endif
          default: begin
            nextState     = FETCH;
            illegalDecode = 1'b1;
          end
        endcase
      end
      MEM_ADDR:  nextState = (heldOp == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  nextState = memReady ? MEM_WB : MEM_READ;
      MEM_WB:    retire = 1'b1;
      MEM_WRITE: begin
        if (memReady) retire = 1'b1;
        else          nextState = MEM_WRITE;
      end
      EXECUTE:   nextState = R_WB;
      R_WB:      retire = 1'b1;
      BRANCH:    retire = 1'b1;
      JUMP:      retire = 1'b1;
`ifdef MULTI_CYCLE_ADDI_EN
      ADDI_EXEC: nextState = ADDI_WB;
      ADDI_WB:   retire = 1'b1;
`endif
      default:   nextState = FETCH;
    endcase
  end

  control_word_decode uDecode (
    .state (stateReg),
    .ctrl  (ctrlRaw)
  );

  // Reset forces every strobe low in the reset cycle itself, aborting any
  // in-flight write before the state register has returned to FETCH.
  assign ctrl = reset ? CTRL_IDLE : ctrlRaw;

  assign pcWrite      = ctrl.pcWrite;
  assign pcWriteCond  = ctrl.pcWriteCond;
  assign pcSource     = ctrl.pcSource;
  assign iorD         = ctrl.iorD;
  assign memRead      = ctrl.memRead;
  assign memWrite     = ctrl.memWrite;
  assign irWrite      = ctrl.irWrite;
  assign memToReg     = ctrl.memToReg;
  assign regDst       = ctrl.regDst;
  assign regWrite     = ctrl.regWrite;
  assign aluSrcA      = ctrl.aluSrcA;
  assign aluSrcB      = ctrl.aluSrcB;
  assign aluOp        = ctrl.aluOp;
  assign illegalOp    = illegalDecode & ~reset;
  assign state        = STATE_W'(stateReg);
  assign retiredCount = retireCnt;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control. Each instruction is planned as
// a list of per-cycle steps (inputs plus expected outputs) pushed to a queue,
// then driven and compared one cycle at a time.
// Optional feature macro: MULTI_CYCLE_ADDI_EN (addi expectations).
module tb_multi_cycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        memReady;
  logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic        memToReg, regDst, regWrite, aluSrcA, illegalOp;
  logic [1:0]  pcSource, aluSrcB, aluOp;
  logic [3:0]  state;
  logic [31:0] retiredCount;
  logic [16:0] dutCtl;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] ret;
  } stepT;

  stepT        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;
  logic [31:0] expRet = 0;

  always #5 clk = ~clk;

  multi_cycle_control #(.STATE_W(4), .RETIRE_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .memReady     (memReady),
    .pcWrite      (pcWrite),
    .pcWriteCond  (pcWriteCond),
    .pcSource     (pcSource),
    .iorD         (iorD),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .irWrite      (irWrite),
    .memToReg     (memToReg),
    .regDst       (regDst),
    .regWrite     (regWrite),
    .aluSrcA      (aluSrcA),
    .aluSrcB      (aluSrcB),
    .aluOp        (aluOp),
    .illegalOp    (illegalOp),
    .state        (state),
    .retiredCount (retiredCount)
  );

  assign dutCtl = {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite,
                   irWrite, memToReg, regDst, regWrite, aluSrcA, aluSrcB,
                   aluOp, illegalOp};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  // Expected control vector straight from the state output table.
  function automatic logic [16:0] expCtl(input logic [3:0] st, input bit ill);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] ps, asb, aop;
    {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
    {ps, asb, aop} = '0;
    case (st)
      4'd0: begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
      4'd1: asb = 2'b11;
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mr = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mw = 1; iord = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      4'd9: begin pw = 1; ps = 2'b10; end
`ifdef MULTI_CYCLE_ADDI_EN
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
`endif
      default: ;
    endcase
    return {pw, pwc, ps, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ill};
  endfunction

  task automatic pushStep(input logic rst, input logic [5:0] op,
                          input logic rdy, input logic [3:0] st, input bit ill);
    stepT s;
    s.rst = rst;
    s.op  = op;
    s.rdy = rdy;
    s.st  = st;
    s.ctl = rst ? 17'd0 : expCtl(st, ill);
    s.ret = expRet;
    sb.push_back(s);
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  // Plans one full instruction; opcode is swapped after DECODE so the
  // captured copy, not the live input, must steer MEM_ADDR.
  task automatic planInstr(input logic [5:0] op, input int stalls);
    bit         legal;
    logic [5:0] other;
    legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ) || (op == OP_J);
`ifdef MULTI_CYCLE_ADDI_EN
    legal = legal || (op == OP_ADDI);
`endif
    other = (op == OP_LW) ? OP_SW : OP_LW;
    pushStep(0, op, rnd(), 4'd0, 0);
    pushStep(0, op, rnd(), 4'd1, !legal);
    if (!legal) return;
    case (op)
      OP_LW: begin
        pushStep(0, other, rnd(), 4'd2, 0);
        for (int i = 0; i < stalls; i++) pushStep(0, other, 0, 4'd3, 0);
        pushStep(0, other, 1, 4'd3, 0);
        pushStep(0, other, rnd(), 4'd4, 0);
      end
      OP_SW: begin
        pushStep(0, other, rnd(), 4'd2, 0);
        for (int i = 0; i < stalls; i++) pushStep(0, other, 0, 4'd5, 0);
        pushStep(0, other, 1, 4'd5, 0);
      end
      OP_RTYPE: begin
        pushStep(0, other, rnd(), 4'd6, 0);
        pushStep(0, other, rnd(), 4'd7, 0);
      end
      OP_BEQ: pushStep(0, other, rnd(), 4'd8, 0);
      OP_J:   pushStep(0, other, rnd(), 4'd9, 0);
      default: begin
        pushStep(0, other, rnd(), 4'd10, 0);
        pushStep(0, other, rnd(), 4'd11, 0);
      end
    endcase
    expRet++;
  endtask

  // Drive each planned step after the falling edge, compare 1 ns later.
  task automatic drain();
    stepT s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      reset    = s.rst;
      opcode   = s.op;
      memReady = s.rdy;
      #1;
      cycle++;
      check("state", 32'(state), 32'(s.st));
      check("ctrl", 32'(dutCtl), 32'(s.ctl));
      check("retired", retiredCount, s.ret);
    end
  endtask

  initial begin
    reset    = 1'b1;
    opcode   = OP_RTYPE;
    memReady = 1'b0;
    @(posedge clk);
    pushStep(1, OP_RTYPE, 0, 4'd0, 0);
    pushStep(1, OP_RTYPE, 0, 4'd0, 0);
    drain();

    planInstr(OP_RTYPE, 0); drain();
    planInstr(OP_LW, 0);    drain();
    planInstr(OP_SW, 3);    drain();
    planInstr(OP_BEQ, 0);   drain();
    planInstr(OP_J, 0);     drain();
    planInstr(6'b111111, 0); drain();
    planInstr(OP_ADDI, 0);  drain();
    planInstr(OP_LW, 2);    drain();

    // Reset during a MEM_READ stall: strobes drop in the reset cycle itself.
    pushStep(0, OP_LW, rnd(), 4'd0, 0);
    pushStep(0, OP_LW, rnd(), 4'd1, 0);
    pushStep(0, OP_SW, rnd(), 4'd2, 0);
    pushStep(0, OP_SW, 0, 4'd3, 0);
    pushStep(0, OP_SW, 0, 4'd3, 0);
    pushStep(1, OP_SW, 1, 4'd3, 0);
    expRet = 0;
    pushStep(1, OP_RTYPE, 1, 4'd0, 0);
    drain();

    planInstr(OP_RTYPE, 0); drain();
    pushStep(0, OP_RTYPE, rnd(), 4'd0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
